// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet test-traffic generator.
// The LFSR tap mask is only used when ETH_PKT_GEN_LFSR_EN is defined.
package eth_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPayload = 3'd1,
        StEnd     = 3'd2,
        StGap     = 3'd3,
        StWaitTx  = 3'd4
    } eth_pkt_gen_state_t;

    // Mode 3 has no enumerator and falls back to incrementing.
    typedef enum logic [1:0] {
        PAT_INC  = 2'd0,
        PAT_FIX  = 2'd1,
        PAT_LFSR = 2'd2
    } eth_pat_mode_t;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting left with feedback into bit 0.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/eth_lfsr8.sv
// 8-bit Fibonacci LFSR pattern source; a zero seed is replaced by 8'h01
// because the all-zero state would lock up.
module eth_lfsr8
    import eth_pkg::*;
(
    input  logic       Clk,
    input  logic       Rstn,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            lfsr_q <= '0;
        end else if (load) begin
            lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (advance) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/eth_pkt_gen.sv
// Programmable test-traffic generator feeding the eth_tx byte interface.
// Optional ETH_PKT_GEN_LFSR_EN adds an LFSR data pattern for Cfg_Mode 2.
module eth_pkt_gen
    import eth_pkg::*;
#(
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned MIN_LEN = 1,
    parameter int unsigned MAX_LEN = 1500,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned GAP_W   = 16
) (
    input  logic             Clk,
    input  logic             Rstn,
    input  logic             Start,
    input  logic [LEN_W-1:0] Cfg_Len,
    input  logic [1:0]       Cfg_Mode,
    input  logic [7:0]       Cfg_Seed,
    input  logic [CNT_W-1:0] Cfg_Pkt_Cnt,
    input  logic [GAP_W-1:0] Cfg_Gap,
    input  logic             Tx_Busy,
    output logic [7:0]       Eth_Byte,
    output logic             Eth_Byte_Valid,
    output logic             Eth_Pkt_Rdy,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Pkts_Sent
);

    localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    eth_pkt_gen_state_t state_q, state_d;

    logic             start_q;
    logic [LEN_W-1:0] len_q, len_d, byte_cnt_q, byte_cnt_d, len_clamped;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       seed_q, seed_d, data_q, data_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d, sent_q, sent_d, sent_inc;
    logic [GAP_W-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic             valid_q, valid_d, rdy_q, rdy_d, done_q, done_d;
    logic             start_rise, last_byte, start_pkt;

    assign start_rise = Start & ~start_q;
    assign last_byte  = (byte_cnt_q == len_q - LEN_W'(1));
    assign sent_inc   = sent_q + CNT_W'(1);

    always_comb begin
        if (Cfg_Len < MinLen) begin
            len_clamped = MinLen;
        end else if (Cfg_Len > MaxLen) begin
            len_clamped = MaxLen;
        end else begin
            len_clamped = Cfg_Len;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        pkt_cnt_d  = pkt_cnt_q;
        gap_d      = gap_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        sent_d     = sent_q;
        valid_d    = 1'b0;
        rdy_d      = 1'b0;
        done_d     = 1'b0;
        start_pkt  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    len_d     = len_clamped;
                    mode_d    = Cfg_Mode;
                    seed_d    = Cfg_Seed;
                    pkt_cnt_d = Cfg_Pkt_Cnt;
                    gap_d     = Cfg_Gap;
                    sent_d    = '0;
                    start_pkt = 1'b1;
                end
            end
            StPayload: begin
                if (last_byte) begin
                    state_d = StEnd;
                    rdy_d   = 1'b1;
                end else begin
                    valid_d    = 1'b1;
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    data_d     = (mode_q == PAT_FIX) ? seed_q : data_q + 8'd1;
                end
            end
            StEnd: begin
                if (sent_q != '1) begin
                    sent_d = sent_inc;
                end
                if (pkt_cnt_q != '0 && sent_inc == pkt_cnt_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (!Start) begin
                    state_d = StIdle;
                end else if (gap_q != '0) begin
                    state_d   = StGap;
                    gap_cnt_d = GAP_W'(1);
                end else if (Tx_Busy) begin
                    state_d = StWaitTx;
                end else begin
                    start_pkt = 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == gap_q) begin
                    if (Tx_Busy) begin
                        state_d = StWaitTx;
                    end else begin
                        start_pkt = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            StWaitTx: begin
                if (!Tx_Busy) begin
                    start_pkt = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // First byte is registered on the same edge that enters PAYLOAD.
        if (start_pkt) begin
            state_d    = StPayload;
            valid_d    = 1'b1;
            byte_cnt_d = '0;
            data_d     = seed_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rstn) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            len_q      <= '0;
            mode_q     <= '0;
            seed_q     <= '0;
            pkt_cnt_q  <= '0;
            gap_q      <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            sent_q     <= '0;
            valid_q    <= 1'b0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= Start;
            len_q      <= len_d;
            mode_q     <= mode_d;
            seed_q     <= seed_d;
            pkt_cnt_q  <= pkt_cnt_d;
            gap_q      <= gap_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            sent_q     <= sent_d;
            valid_q    <= valid_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
        end
    end

`ifdef ETH_PKT_GEN_LFSR_EN
    logic       lfsr_load, lfsr_advance;
    logic [7:0] lfsr_value;

    assign lfsr_load    = start_pkt;
    // The last byte of a packet does not advance, so the output holds afterwards.
    assign lfsr_advance = (state_q == StPayload) && !last_byte;

    eth_lfsr8 u_lfsr (
        .Clk     (Clk),
        .Rstn    (Rstn),
        .load    (lfsr_load),
        .advance (lfsr_advance),
        .seed    (seed_d),
        .value   (lfsr_value)
    );

    assign Eth_Byte = (mode_q == PAT_LFSR) ? lfsr_value : data_q;
`else
    assign Eth_Byte = data_q;
`endif

    assign Eth_Byte_Valid = valid_q;
    assign Eth_Pkt_Rdy    = rdy_q;
    assign Done           = done_q;
    assign Pkts_Sent      = sent_q;
    assign Busy           = (state_q != StIdle);

endmodule

// File: tb/tb_eth_pkt_gen.sv
// Directed self-checking bench for eth_pkt_gen; a negedge monitor records the
// byte stream and event cycles, and each test compares against hand-derived values.
`timescale 1ns/1ps
module tb_eth_pkt_gen;

    localparam int LEN_W = 11;
    localparam int CNT_W = 16;
    localparam int GAP_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic             tx_busy;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [1:0]       cfg_mode = '0;
    logic [7:0]       cfg_seed = '0;
    logic [CNT_W-1:0] cfg_pkt_cnt = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic [7:0]       eth_byte;
    logic             eth_valid, pkt_rdy, busy, done;
    logic [CNT_W-1:0] pkts_sent;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eth_pkt_gen dut (
        .Clk            (clk),
        .Rstn           (rstn),
        .Start          (start),
        .Cfg_Len        (cfg_len),
        .Cfg_Mode       (cfg_mode),
        .Cfg_Seed       (cfg_seed),
        .Cfg_Pkt_Cnt    (cfg_pkt_cnt),
        .Cfg_Gap        (cfg_gap),
        .Tx_Busy        (tx_busy),
        .Eth_Byte       (eth_byte),
        .Eth_Byte_Valid (eth_valid),
        .Eth_Pkt_Rdy    (pkt_rdy),
        .Busy           (busy),
        .Done           (done),
        .Pkts_Sent      (pkts_sent)
    );

    // Monitor: cycle index, valid bytes, packet starts, Pkt_Rdy and Done cycles.
    int unsigned cyc = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  bytes[$];
    int unsigned first_cyc[$];
    int unsigned rdy_cyc[$];
    int unsigned done_cnt = 0;
    int unsigned done_cyc = 0;
    int unsigned last_valid_cyc = 0;
    logic        busy_model = 1'b0;
    int unsigned busy_left = 0;

    assign tx_busy = (busy_left != 0);

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (eth_valid) begin
            bytes.push_back(eth_byte);
            if (!prev_valid) first_cyc.push_back(cyc);
            last_valid_cyc = cyc;
        end
        if (pkt_rdy) rdy_cyc.push_back(cyc);
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        prev_valid = eth_valid;
        // eth_tx stand-in: busy from the Pkt_Rdy cycle, sampled high on 9 edges.
        if (busy_model && pkt_rdy) busy_left = 9;
        else if (busy_left != 0) busy_left = busy_left - 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic setup(input int len, input int mode, input int seed, input int cnt,
                         input int gap);
        cfg_len     = LEN_W'(len);
        cfg_mode    = 2'(mode);
        cfg_seed    = 8'(seed);
        cfg_pkt_cnt = CNT_W'(cnt);
        cfg_gap     = GAP_W'(gap);
        bytes.delete();
        first_cyc.delete();
        rdy_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic rise_start(output int unsigned t0);
        @(negedge clk);
        #1;
        start = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy && n < budget);
        if (busy) check_eq({tag, "_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic wait_cond_bytes(input string tag, input int nbytes, input int budget);
        int n = 0;
        while (bytes.size() < nbytes && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bytes.size() < nbytes) check_eq({tag, "_timeout"}, 64'(bytes.size()), 64'(nbytes));
    endtask

    task automatic wait_pkts(input string tag, input int npkts, input int budget);
        int n = 0;
        while (first_cyc.size() < npkts && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (first_cyc.size() < npkts) check_eq({tag, "_timeout"}, 64'(first_cyc.size()), 64'(npkts));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int inc_err(input int base, input int n, input int seed);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (bytes[base + i] !== 8'(seed + i)) e++;
        end
        return e;
    endfunction

    function automatic int lfsr_err(input int base, input int n, input logic [7:0] seed);
        int e = 0;
        logic [7:0] v;
        v = (seed == 8'h00) ? 8'h01 : seed;
        for (int i = 0; i < n; i++) begin
            if (bytes[base + i] !== v) e++;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
        return e;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;

        // Reset state
        setup(100, 0, 1, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(eth_valid), 64'd0);
        check_eq("rst_byte", 64'(eth_byte), 64'd0);
        check_eq("rst_rdy", 64'(pkt_rdy), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_sent", 64'(pkts_sent), 64'd0);
        rstn = 1'b1;
        idle_cycles(2);

        // Basic 100-byte packet, seed 1
        setup(100, 0, 1, 1, 0);
        rise_start(t0);
        wait_idle("basic", 400);
        idle_cycles(1);
        check_eq("basic_nbytes", 64'(bytes.size()), 64'd100);
        check_eq("basic_runs", 64'(first_cyc.size()), 64'd1);
        check_eq("basic_latency", 64'(first_cyc[0] - t0), 64'd1);
        check_eq("basic_first", 64'(bytes[0]), 64'd1);
        check_eq("basic_last", 64'(bytes[99]), 64'd100);
        check_eq("basic_data", 64'(inc_err(0, 100, 1)), 64'd0);
        check_eq("basic_nrdy", 64'(rdy_cyc.size()), 64'd1);
        check_eq("basic_rdy_after_last", 64'(rdy_cyc[0] - last_valid_cyc), 64'd1);
        check_eq("basic_ndone", 64'(done_cnt), 64'd1);
        check_eq("basic_done_after_rdy", 64'(done_cyc - rdy_cyc[0]), 64'd1);
        check_eq("basic_sent", 64'(pkts_sent), 64'd1);
        check_eq("basic_busy", 64'(busy), 64'd0);
        start = 1'b0;
        idle_cycles(2);

        // Length 0 clamps to one byte
        setup(0, 0, 7, 1, 0);
        rise_start(t0);
        wait_idle("len0", 50);
        idle_cycles(1);
        check_eq("len0_nbytes", 64'(bytes.size()), 64'd1);
        check_eq("len0_byte", 64'(bytes[0]), 64'd7);
        check_eq("len0_ndone", 64'(done_cnt), 64'd1);
        start = 1'b0;
        idle_cycles(2);

        // Length 2047 clamps to 1500; seed 0 ends on 1499 mod 256 = 219
        setup(2047, 0, 0, 1, 0);
        rise_start(t0);
        wait_idle("lenmax", 2000);
        idle_cycles(1);
        check_eq("lenmax_nbytes", 64'(bytes.size()), 64'd1500);
        check_eq("lenmax_last", 64'(bytes[1499]), 64'd219);
        check_eq("lenmax_data", 64'(inc_err(0, 1500, 0)), 64'd0);
        start = 1'b0;
        idle_cycles(2);

        // Incrementing wrap from FE
        setup(4, 0, 8'hFE, 1, 0);
        rise_start(t0);
        wait_idle("wrap", 50);
        check_eq("wrap_nbytes", 64'(bytes.size()), 64'd4);
        check_eq("wrap_b0", 64'(bytes[0]), 64'hFE);
        check_eq("wrap_b1", 64'(bytes[1]), 64'hFF);
        check_eq("wrap_b2", 64'(bytes[2]), 64'h00);
        check_eq("wrap_b3", 64'(bytes[3]), 64'h01);
        start = 1'b0;
        idle_cycles(2);

        // Fixed pattern, mode 3 (incrementing) in the same shape
        setup(5, 1, 8'hA5, 1, 0);
        rise_start(t0);
        wait_idle("fix", 50);
        check_eq("fix_nbytes", 64'(bytes.size()), 64'd5);
        check_eq("fix_b0", 64'(bytes[0]), 64'hA5);
        check_eq("fix_b4", 64'(bytes[4]), 64'hA5);
        start = 1'b0;
        idle_cycles(2);
        setup(3, 3, 8'h20, 1, 0);
        rise_start(t0);
        wait_idle("mode3", 50);
        check_eq("mode3_data", 64'(inc_err(0, 3, 8'h20)), 64'd0);
        start = 1'b0;
        idle_cycles(2);

        // Three packets, gap 5 hidden under Tx_Busy; a Start re-rise mid-packet is ignored
        busy_model = 1'b1;
        setup(8, 0, 8'h10, 3, 5);
        rise_start(t0);
        idle_cycles(1);
        start = 1'b0;
        idle_cycles(1);
        start = 1'b1;
        wait_idle("multi", 300);
        idle_cycles(1);
        check_eq("multi_nbytes", 64'(bytes.size()), 64'd24);
        check_eq("multi_npkts", 64'(first_cyc.size()), 64'd3);
        check_eq("multi_nrdy", 64'(rdy_cyc.size()), 64'd3);
        check_eq("multi_data0", 64'(inc_err(0, 8, 8'h10)), 64'd0);
        check_eq("multi_data1", 64'(inc_err(8, 8, 8'h10)), 64'd0);
        check_eq("multi_data2", 64'(inc_err(16, 8, 8'h10)), 64'd0);
        check_eq("multi_busy_gap1", 64'(first_cyc[1] - rdy_cyc[0]), 64'd10);
        check_eq("multi_busy_gap2", 64'(first_cyc[2] - rdy_cyc[1]), 64'd10);
        check_eq("multi_ndone", 64'(done_cnt), 64'd1);
        check_eq("multi_sent", 64'(pkts_sent), 64'd3);
        start = 1'b0;
        busy_model = 1'b0;
        idle_cycles(12);

        // Continuous run, gap 2 without busy, Start dropped during packet 4
        setup(6, 0, 0, 0, 2);
        rise_start(t0);
        wait_pkts("cont", 4, 200);
        start = 1'b0;
        wait_idle("cont", 100);
        idle_cycles(1);
        check_eq("cont_gap", 64'(first_cyc[1] - rdy_cyc[0]), 64'd3);
        check_eq("cont_nbytes", 64'(bytes.size()), 64'd24);
        check_eq("cont_nrdy", 64'(rdy_cyc.size()), 64'd4);
        check_eq("cont_ndone", 64'(done_cnt), 64'd0);
        check_eq("cont_sent", 64'(pkts_sent), 64'd4);
        check_eq("cont_busy", 64'(busy), 64'd0);
        idle_cycles(2);

        // Mode 2 with seed 0
        setup(10, 2, 0, 1, 0);
        rise_start(t0);
        wait_idle("lfsr", 50);
        check_eq("lfsr_nbytes", 64'(bytes.size()), 64'd10);
`ifdef ETH_PKT_GEN_LFSR_EN
        check_eq("lfsr_first", 64'(bytes[0]), 64'h01);
        check_eq("lfsr_data", 64'(lfsr_err(0, 10, 8'h00)), 64'd0);
`else
        check_eq("lfsr_first", 64'(bytes[0]), 64'h00);
        check_eq("lfsr_data", 64'(inc_err(0, 10, 0)), 64'd0);
`endif
        start = 1'b0;
        idle_cycles(2);

        // Reset at byte 50, then a fresh run
        setup(100, 0, 0, 1, 0);
        rise_start(t0);
        wait_cond_bytes("midrst", 50, 100);
        rstn = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_valid", 64'(eth_valid), 64'd0);
        check_eq("midrst_byte", 64'(eth_byte), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_rdy", 64'(pkt_rdy), 64'd0);
        check_eq("midrst_sent", 64'(pkts_sent), 64'd0);
        idle_cycles(2);
        rstn = 1'b1;
        idle_cycles(3);
        check_eq("midrst_nrdy", 64'(rdy_cyc.size()), 64'd0);
        check_eq("midrst_nbytes", 64'(bytes.size()), 64'd50);
        setup(3, 0, 9, 1, 0);
        rise_start(t0);
        wait_idle("afterrst", 50);
        idle_cycles(1);
        check_eq("afterrst_latency", 64'(first_cyc[0] - t0), 64'd1);
        check_eq("afterrst_data", 64'(inc_err(0, 3, 9)), 64'd0);
        check_eq("afterrst_nbytes", 64'(bytes.size()), 64'd3);
        check_eq("afterrst_ndone", 64'(done_cnt), 64'd1);
        check_eq("afterrst_sent", 64'(pkts_sent), 64'd1);
        start = 1'b0;
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
